dispatch_credit_arb: RTL and testbench
======================================

# dispatch_credit_arb

Credit-based round-robin scheduler that shares one execution-unit dispatch port among `NUM_REQS` issue slots. It sits between the per-slot dispatch buffers and the execution unit's input queue. It grants at most one request per cycle, tracks free entries in the downstream queue with a credit counter, and drives a registered output with no ready signal. Downstream acceptance is guaranteed by the credit protocol.

## Interface
Parameters:
- `NUM_REQS`, default 4: number of requesting issue slots (≥1).
- `DATAW`, default 64: payload width per request.
- `CREDITS`, default 4: downstream queue depth (≥1).
- `PERF_CTR_BITS`, default 44: width of the stall counter.
- Derived: `SELW = max(1, clog2(NUM_REQS))`, `CNTW = clog2(CREDITS+1)`.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `req_valid` in `NUM_REQS`: per-slot request valid.
- `req_data` in `NUM_REQS×DATAW`: per-slot payload.
- `req_ready` out `NUM_REQS`: one-hot grant; combinational in the same cycle.
- `out_valid` out 1: registered dispatch valid.
- `out_data` out `DATAW`: registered payload.
- `out_sel` out `SELW`: index of the granted slot for `out_data`.
- `credit_return` in 1: single-cycle pulse; downstream freed one entry.
- `credits_avail` out `CNTW`: current credit count.
- `credit_err` out 1: sticky flag for credit overflow.
- `perf_credit_stalls` out `PERF_CTR_BITS`: stall-cycle counter.

## Operation
- `can_grant = (credits_avail != 0)`. Same-cycle `credit_return` does not enable a grant; this is a deliberate simplification.
- Arbitration is round-robin over `req_valid`. The search starts at `rr_ptr`, and the first valid slot at or after `rr_ptr` (wrapping) wins.
- When `can_grant` is high and any `req_valid` is set:
  - `req_ready[w]` = 1 for the winner `w` only; all other bits are 0.
  - The handshake completes on `req_valid[w] & req_ready[w]`.
- When `can_grant` is low: `req_ready` = 0.
- On grant:
  - `rr_ptr` ← `(w+1) mod NUM_REQS`.
  - `out_data` ← `req_data[w]`, `out_sel` ← `w`, `out_valid` ← 1.
- With no grant: `out_valid` ← 0. `out_data` and `out_sel` hold their last values.
- Credit update: `cnt_next = cnt - grant + credit_return`, computed in `CNTW+1` bits.
  - Grant and return in the same cycle leave the count unchanged.
  - Overflow is `credit_return` while `cnt == CREDITS` with no grant. The counter stays at `CREDITS` and `credit_err` ← 1. `credit_err` stays set until reset.
- Stall counter: increments when `|req_valid && cnt == 0`. It wraps modulo 2^`PERF_CTR_BITS`.
- Requesters must hold `req_valid`/`req_data` until granted. The block does not check this.

## Timing
- Latency: a grant in cycle t produces `out_valid` = 1 with its payload in cycle t+1, for exactly one cycle per grant.
- Throughput: 1 dispatch/cycle while credits remain. Back-to-back grants give continuous `out_valid`.
- Credits: a grant in cycle t reduces `credits_avail` at t+1. A return in cycle t raises it at t+1.
- After `CREDITS` consecutive grants with no returns, `req_ready` = 0 from the next cycle. The first grant after a return pulse in cycle t can occur at t+1.
- Reset values while `reset_n` = 0 (asynchronous assert, synchronous-style deassert via the normal reset relay):
  - `out_valid`=0, `out_data`=0, `out_sel`=0
  - `rr_ptr`=0, `credits_avail`=`CREDITS`
  - `credit_err`=0, `perf_credit_stalls`=0
- `req_ready` is forced to 0 during reset.
- Reset mid-stream drops the in-flight output. Downstream must be reset in the same domain.
- With `NUM_REQS`=1, arbitration degenerates to `req_ready = can_grant`, and `out_sel` = 0.

## Structure
- Shared package holds:
  - the credit counter width helper `clog2(CREDITS+1)`;
  - the `SELW` derivation;
  - a `dispatch_req_t` struct typedef for the payload, when `DATAW` matches the dispatch data format.
- One sub-module, `rr_grant_sel`:
  - inputs: `valid` vector and `rr_ptr`;
  - outputs: one-hot grant, binary index, `any`;
  - purely combinational; `rr_ptr` lives in the parent.
- The parent holds the output register, credit counter, error flag and perf counter.

## Test plan
- Reset, `CREDITS`=4, all slots idle:
  - `credits_avail`=4, `out_valid`=0, `req_ready`=0000, `credit_err`=0.
- All four slots valid continuously, `credit_return` held at 0:
  - grants go to slots 0,1,2,3 in order;
  - `out_sel` = 0,1,2,3 on cycles 1–4;
  - `req_ready` = 0 from cycle 4 onward;
  - `perf_credit_stalls` increments each later cycle.
- From 0 credits, pulse `credit_return` once with slots 2 and 3 valid and `rr_ptr`=0:
  - one grant to slot 2 on the next cycle;
  - `credits_avail` returns to 0.
- With `credits_avail`=2, a grant and a `credit_return` in the same cycle:
  - `credits_avail` stays 2;
  - the next grant proceeds without a bubble.
- With `credits_avail`=4, pulse `credit_return`:
  - `credits_avail` stays 4;
  - `credit_err`=1 and stays set until reset.
- Assert `reset_n`=0 asynchronously mid-burst, between clock edges:
  - `out_valid` drops to 0 immediately;
  - after release, `credits_avail`=4 and the first grant goes to the lowest valid slot.

Source files
------------

// File: rtl/dispatch_credit_arb_pkg.sv
// Shared widths and payload format for the credit-based dispatch arbiter.
package dispatch_credit_arb_pkg;

   // Width of a slot index; never narrower than one bit, so a single-slot build stays legal.
   function automatic int sel_width(input int num_reqs);
      return (num_reqs > 1) ? $clog2(num_reqs) : 1;
   endfunction

   // Width needed to hold every credit value from 0 to CREDITS inclusive.
   function automatic int cnt_width(input int credits);
      return $clog2(credits + 1);
   endfunction

   typedef struct packed {
      logic [7:0]  uop;
      logic [5:0]  rd;
      logic [49:0] operand;
   } dispatch_req_t;

   localparam int DISPATCH_REQ_W = $bits(dispatch_req_t);

endpackage

// File: rtl/dispatch_credit_arb_rr_grant_sel.sv
// Combinational round-robin picker: first valid slot at or after rr_ptr_i, wrapping.
module rr_grant_sel
   import dispatch_credit_arb_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int SELW     = sel_width(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] valid_i,
   input  logic [SELW-1:0]     rr_ptr_i,
   output logic [NUM_REQS-1:0] grant_o,
   output logic [SELW-1:0]     idx_o,
   output logic                any_o
);

   logic [SELW-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         cand = SELW'((int'(rr_ptr_i) + k) % NUM_REQS);
         if (!any_o && valid_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      grant_o[idx_o] = any_o;
   end

endmodule

// File: rtl/dispatch_credit_arb.sv
// Credit-gated round-robin scheduler feeding one registered dispatch port.
module dispatch_credit_arb
   import dispatch_credit_arb_pkg::*;
#(
   parameter int NUM_REQS      = 4,
   parameter int DATAW         = 64,
   parameter int CREDITS       = 4,
   parameter int PERF_CTR_BITS = 44
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_REQS-1:0]               req_valid,
   input  logic [NUM_REQS*DATAW-1:0]         req_data,
   output logic [NUM_REQS-1:0]               req_ready,
   output logic                              out_valid,
   output logic [DATAW-1:0]                  out_data,
   output logic [sel_width(NUM_REQS)-1:0]    out_sel,
   input  logic                              credit_return,
   output logic [cnt_width(CREDITS)-1:0]     credits_avail,
   output logic                              credit_err,
   output logic [PERF_CTR_BITS-1:0]          perf_credit_stalls
);

   localparam int SELW = sel_width(NUM_REQS);
   localparam int CNTW = cnt_width(CREDITS);

   logic [DATAW-1:0]         req_data_arr [NUM_REQS];
   logic [NUM_REQS-1:0]      grant_vec;
   logic [SELW-1:0]          win_idx;
   logic                     any_valid;
   logic                     can_grant;
   logic                     grant;
   logic                     overflow;
   logic [CNTW:0]            cnt_sum;

   logic [SELW-1:0]          rr_ptr_q, rr_ptr_d;
   logic                     out_valid_q, out_valid_d;
   logic [DATAW-1:0]         out_data_q, out_data_d;
   logic [SELW-1:0]          out_sel_q, out_sel_d;
   logic [CNTW-1:0]          cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic [PERF_CTR_BITS-1:0] stall_q, stall_d;

   generate
      for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
         assign req_data_arr[gi] = req_data[gi*DATAW +: DATAW];
      end
   endgenerate

   rr_grant_sel #(
      .NUM_REQS (NUM_REQS),
      .SELW     (SELW)
   ) u_rr_grant_sel (
      .valid_i  (req_valid),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (grant_vec),
      .idx_o    (win_idx),
      .any_o    (any_valid)
   );

   // A return in this cycle does not count towards granting; only registered credits do.
   assign can_grant = (cnt_q != '0) && reset_n;
   assign grant     = can_grant && any_valid;
   assign req_ready = grant_vec & {NUM_REQS{can_grant}};

   assign overflow = credit_return && !grant && (cnt_q == CNTW'(CREDITS));
   assign cnt_sum  = {1'b0, cnt_q} - (CNTW+1)'(grant) + (CNTW+1)'(credit_return);

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = grant;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      cnt_d       = overflow ? cnt_q : cnt_sum[CNTW-1:0];
      err_d       = err_q | overflow;
      stall_d     = stall_q;
      if (grant) begin
         rr_ptr_d   = (win_idx == SELW'(NUM_REQS - 1)) ? '0 : win_idx + SELW'(1);
         out_data_d = req_data_arr[win_idx];
         out_sel_d  = win_idx;
      end
      if (|req_valid && (cnt_q == '0)) begin
         stall_d = stall_q + PERF_CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         cnt_q       <= CNTW'(CREDITS);
         err_q       <= 1'b0;
         stall_q     <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         stall_q     <= stall_d;
      end
   end

   assign out_valid          = out_valid_q;
   assign out_data           = out_data_q;
   assign out_sel            = out_sel_q;
   assign credits_avail      = cnt_q;
   assign credit_err         = err_q;
   assign perf_credit_stalls = stall_q;

endmodule

// File: tb/tb_dispatch_credit_arb.sv
// Directed plus random bench for dispatch_credit_arb with a reference model and output scoreboard.
module tb_dispatch_credit_arb;

   localparam int NR = 4;
   localparam int DW = 64;
   localparam int CR = 4;
   localparam int PB = 44;
   localparam int SW = 2;
   localparam int CW = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_sel;
   logic              credit_return;
   logic [CW-1:0]     credits_avail;
   logic              credit_err;
   logic [PB-1:0]     perf_credit_stalls;

   typedef struct packed {
      logic          v;
      logic [SW-1:0] sel;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            m_ptr;
   int            m_cnt;
   logic          m_err;
   longint        m_stall;
   logic [SW-1:0] m_sel;
   logic [DW-1:0] m_data;

   dispatch_credit_arb #(
      .NUM_REQS      (NR),
      .DATAW         (DW),
      .CREDITS       (CR),
      .PERF_CTR_BITS (PB)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .req_valid          (req_valid),
      .req_data           (req_data),
      .req_ready          (req_ready),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_sel            (out_sel),
      .credit_return      (credit_return),
      .credits_avail      (credits_avail),
      .credit_err         (credit_err),
      .perf_credit_stalls (perf_credit_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pay(input int s, input int c);
      return {8'(s), 24'hC0FFEE, 32'(c)};
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_cnt   = CR;
      m_err   = 1'b0;
      m_stall = 0;
      m_sel   = '0;
      m_data  = '0;
      sb.delete();
   endtask

   // One clock of stimulus: drive, check ready, model the edge, then check registered outputs.
   task automatic step(input logic [NR-1:0] v, input logic r);
      exp_t          e;
      logic [NR-1:0] er;
      int            w;
      int            j;
      bit            g;
      cyc++;
      req_valid     = v;
      credit_return = r;
      for (int s = 0; s < NR; s++) req_data[s*DW +: DW] = pay(s, cyc);
      #1;
      er = '0;
      w  = -1;
      if (m_cnt != 0) begin
         for (int k = 0; k < NR; k++) begin
            j = (m_ptr + k) % NR;
            if (w < 0 && v[j]) w = j;
         end
      end
      g = (w >= 0);
      if (g) er[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (g) begin
         m_sel  = SW'(w);
         m_data = pay(w, cyc);
         m_ptr  = (w + 1) % NR;
      end
      e.v    = g;
      e.sel  = m_sel;
      e.data = m_data;
      sb.push_back(e);
      if ((|v) && m_cnt == 0) m_stall++;
      if (r && !g && m_cnt == CR) m_err = 1'b1;
      else m_cnt = m_cnt - int'(g) + int'(r);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk("out_valid", 64'(out_valid), 64'(e.v));
         chk("out_sel", 64'(out_sel), 64'(e.sel));
         chk("out_data", out_data, e.data);
      end
      chk("credits_avail", 64'(credits_avail), 64'(m_cnt));
      chk("credit_err", 64'(credit_err), 64'(m_err));
      chk("perf_credit_stalls", 64'(perf_credit_stalls), 64'(m_stall));
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = '0;
      credit_return = 1'b0;
      req_data      = '0;
      model_reset();

      // Reset state, with requests present to show ready stays low.
      @(posedge clk);
      #1;
      req_valid = '1;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_credits", 64'(credits_avail), 64'(CR));
      chk("rst_credit_err", 64'(credit_err), 64'(0));
      chk("rst_out_sel", 64'(out_sel), 64'(0));
      chk("rst_out_data", out_data, 64'(0));
      chk("rst_perf", 64'(perf_credit_stalls), 64'(0));
      @(posedge clk);
      #1;
      req_valid = '0;
      reset_n   = 1'b1;

      step(4'b0000, 1'b0);

      // Burst until credits run out, then stall cycles.
      repeat (7) step(4'b1111, 1'b0);

      // Single return from empty with slots 2 and 3 valid.
      step(4'b1100, 1'b1);
      step(4'b1100, 1'b0);
      step(4'b0000, 1'b0);

      // Bring credits to 2, then grant and return together.
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b0);
      repeat (3) step(4'b0000, 1'b1);

      // Overflow at full credits; the error flag must stick.
      step(4'b0000, 1'b1);
      repeat (2) step(4'b0000, 1'b0);

      // Asynchronous reset between edges in the middle of a burst.
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'(0));
      chk("async_rst_credits", 64'(credits_avail), 64'(CR));
      chk("async_rst_credit_err", 64'(credit_err), 64'(0));
      chk("async_rst_req_ready", 64'(req_ready), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(4'b0110, 1'b0);
      step(4'b0110, 1'b0);

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         step(NR'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
